// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the instruction-register / control
// slice (state encoding, opcode fields, ALU operation codes, instruction class).
package cpu_pkg;

    localparam int IW  = 16;  // instruction width; the field layout below needs 16
    localparam int RAW = 3;   // register-file address width

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG,
        S_WRITE_IMM,
        S_HALT
    } state_e;

    // Major opcode in ir[15:13]
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // Sub-opcode in ir[12:11], meaning depends on the major opcode
    localparam logic [1:0] SUB_MOV_IMM = 2'b10;
    localparam logic [1:0] SUB_MOV_REG = 2'b00;
    localparam logic [1:0] SUB_ADD     = 2'b00;
    localparam logic [1:0] SUB_CMP     = 2'b01;
    localparam logic [1:0] SUB_AND     = 2'b10;
    localparam logic [1:0] SUB_MVN     = 2'b11;

    // ALU operation codes driven on ALUop
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN,
        CLS_ILLEGAL
    } instr_cls_e;

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction handshake (s/load/in/w) plus the datapath control
// bundle. master = controller side, slave = host/datapath side.
interface cpu_ctrl_if;
    import cpu_pkg::*;

    logic           s;
    logic           load;
    logic [IW-1:0]  in;
    logic           w;
    logic [RAW-1:0] readnum;
    logic [RAW-1:0] writenum;
    logic           write;
    logic           vsel;
    logic           loada;
    logic           loadb;
    logic           loadc;
    logic           loads;
    logic           asel;
    logic           bsel;
    logic [1:0]     shift;
    logic [1:0]     ALUop;
    logic [IW-1:0]  datapath_in;
    logic           illegal;

    modport master (
        input  s, load, in,
        output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, datapath_in, illegal
    );

    modport slave (
        output s, load, in,
        input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, bsel, shift, ALUop, datapath_in, illegal
    );

endinterface

// File: rtl/cpu_ctrl_instr_dec.sv
// instr_dec: purely combinational split of the instruction register into
// register fields, shift amount, sign-extended immediates and an instruction class.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [IW-1:0]  ir,
    output logic [RAW-1:0] rn,
    output logic [RAW-1:0] rd,
    output logic [RAW-1:0] rm,
    output logic [1:0]     sh,
    output logic [IW-1:0]  sximm5,
    output logic [IW-1:0]  sximm8,
    output instr_cls_e     cls
);

    logic [2:0] op;
    logic [1:0] sub;

    assign op     = ir[15:13];
    assign sub    = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // Classify the op/sub pair; any combination not listed is illegal.
    always_comb begin
        // NOTE: default assigned first so every path drives cls and no latch is inferred.
        cls = CLS_ILLEGAL;
        case (op)
            OP_MOV: begin
                case (sub)
                    SUB_MOV_IMM: cls = CLS_MOV_IMM;
                    SUB_MOV_REG: cls = CLS_MOV_REG;
                    default:     cls = CLS_ILLEGAL;
                endcase
            end
            OP_ALU: begin
                case (sub)
                    SUB_ADD: cls = CLS_ADD;
                    SUB_CMP: cls = CLS_CMP;
                    SUB_AND: cls = CLS_AND;
                    SUB_MVN: cls = CLS_MVN;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register plus multicycle Moore control FSM driving the
// datapath. w=1 only in WAIT. Optional feature macro CTRL_ILLEGAL_TRAP_EN:
// when defined an illegal opcode parks the FSM in HALT with illegal=1 until
// reset; when undefined an illegal opcode is a two-edge NOP and illegal is 0.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    cpu_ctrl_if.master bus
);

    state_e         state;
    state_e         state_nxt;
    logic [IW-1:0]  ir;

    logic [RAW-1:0] rn;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rm;
    logic [1:0]     sh;
    logic [IW-1:0]  sximm5;
    logic [IW-1:0]  sximm8;
    instr_cls_e     cls;

    instr_dec u_dec (
        .ir     (ir),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm5 (sximm5),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // State register; reset returns to WAIT from anywhere, including mid-instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            // NOTE: non-blocking so state and IR both update from pre-edge values.
            state <= state_nxt;
        end
    end

    // Instruction register: loads only while idle, so DECODE sees the word
    // captured on the same edge that accepted s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (state == S_WAIT && bus.load) begin
            ir <= bus.in;
        end
    end

    // Next state and Moore outputs, decoded from state and IR only.
    always_comb begin
        state_nxt       = state;
        bus.w           = 1'b0;
        bus.readnum     = '0;
        bus.writenum    = '0;
        bus.write       = 1'b0;
        bus.vsel        = 1'b0;
        bus.loada       = 1'b0;
        bus.loadb       = 1'b0;
        bus.loadc       = 1'b0;
        bus.loads       = 1'b0;
        bus.asel        = 1'b0;
        bus.bsel        = 1'b0;
        bus.shift       = 2'b00;
        bus.ALUop       = ALU_ADD;
        bus.datapath_in = sximm5;

        case (state)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                   state_nxt = S_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:          state_nxt = S_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:     state_nxt = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:                       state_nxt = S_HALT;
`else
                    default:                       state_nxt = S_WAIT;
`endif
                endcase
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_nxt   = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_nxt   = S_ALU;
            end
            S_ALU: begin
                bus.bsel  = 1'b1;
                bus.shift = sh;
                // Single-operand instructions feed zero on the A side.
                bus.asel  = (cls != CLS_MOV_REG) && (cls != CLS_MVN);
                case (cls)
                    CLS_CMP: bus.ALUop = ALU_SUB;
                    CLS_AND: bus.ALUop = ALU_AND;
                    CLS_MVN: bus.ALUop = ALU_NOTB;
                    default: bus.ALUop = ALU_ADD;
                endcase
                if (cls == CLS_CMP) begin
                    bus.loads = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_nxt = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                bus.vsel     = 1'b0;
                bus.writenum = rd;
                bus.write    = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WRITE_IMM: begin
                bus.vsel        = 1'b1;
                bus.writenum    = rn;
                bus.write       = 1'b1;
                bus.datapath_in = sximm8;
                state_nxt       = S_WAIT;
            end
            S_HALT: begin
                // Parked until reset; every output stays at its default.
                state_nxt = S_HALT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // HALT is left only by reset, so the state itself is the sticky flag.
    assign bus.illegal = (state == S_HALT);
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed stimulus for cpu_ctrl. A trace-level reference model
// predicts the output vector of every cycle; a compare process checks it at
// each falling edge, and literal expectations pin the model for key vectors.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic [15:0] dp_in;
        logic       illegal;
    } ctl_t;

    logic clk;
    logic reset;
    cpu_ctrl_if bus ();

    cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] m_ir = 16'h0000;
    ctl_t        exp_q[$];
    bit          halt_pending = 0;
    bit          halted = 0;
    bit          cmp_en = 0;

    // Trace recorded by the directed runner
    ctl_t tr[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic ctl_t dut_snap();
        ctl_t c;
        c.w        = bus.w;
        c.readnum  = bus.readnum;
        c.writenum = bus.writenum;
        c.write    = bus.write;
        c.vsel     = bus.vsel;
        c.loada    = bus.loada;
        c.loadb    = bus.loadb;
        c.loadc    = bus.loadc;
        c.loads    = bus.loads;
        c.asel     = bus.asel;
        c.bsel     = bus.bsel;
        c.shift    = bus.shift;
        c.aluop    = bus.ALUop;
        c.dp_in    = bus.datapath_in;
        c.illegal  = bus.illegal;
        return c;
    endfunction

    // Everything inactive; datapath_in still shows the 5-bit immediate of the IR.
    function automatic ctl_t blank(input logic [15:0] ir);
        ctl_t c;
        c       = '0;
        c.dp_in = 16'($signed(ir[4:0]));
        return c;
    endfunction

    // Queue the per-cycle output vectors that follow the edge which accepts s.
    function automatic void plan(input logic [15:0] ir);
        logic [2:0] op;
        logic [1:0] sub;
        ctl_t       c;
        bit         is_alu;
        bit         is_movr;
        bit         uses_a;
        bit         is_cmp;
        op      = ir[15:13];
        sub     = ir[12:11];
        is_alu  = (op == 3'd5);
        is_movr = (op == 3'd6) && (sub == 2'd0);
        uses_a  = is_alu && (sub != 2'd3);
        is_cmp  = is_alu && (sub == 2'd1);
        exp_q.push_back(blank(ir));  // decode cycle: nothing enabled
        if (op == 3'd6 && sub == 2'd2) begin
            c          = blank(ir);
            c.vsel     = 1'b1;
            c.writenum = ir[10:8];
            c.write    = 1'b1;
            c.dp_in    = 16'($signed(ir[7:0]));
            exp_q.push_back(c);
        end else if (is_alu || is_movr) begin
            if (uses_a) begin
                c         = blank(ir);
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
                exp_q.push_back(c);
            end
            c         = blank(ir);
            c.readnum = ir[2:0];
            c.loadb   = 1'b1;
            exp_q.push_back(c);
            c       = blank(ir);
            c.bsel  = 1'b1;
            c.shift = ir[4:3];
            c.asel  = uses_a;
            c.aluop = is_alu ? sub : 2'd0;  // ALU sub-opcodes map 1:1 onto ALUop
            if (is_cmp) c.loads = 1'b1;
            else        c.loadc = 1'b1;
            exp_q.push_back(c);
            if (!is_cmp) begin
                c          = blank(ir);
                c.writenum = ir[7:5];
                c.write    = 1'b1;
                exp_q.push_back(c);
            end
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            halt_pending = 1;
`endif
        end
    endfunction

    function automatic void model_reset();
        m_ir = 16'h0000;
        exp_q.delete();
        halt_pending = 0;
        halted = 0;
    endfunction

    function automatic ctl_t model_now();
        ctl_t c;
        if (halted) begin
            c         = blank(m_ir);
            c.illegal = 1'b1;
        end else if (exp_q.size() > 0) begin
            c = exp_q[0];
        end else begin
            c   = blank(m_ir);
            c.w = 1'b1;
        end
        return c;
    endfunction

    // Model advance on each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                model_reset();
            end else if (halted) begin
                // stuck until reset
            end else if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0 && halt_pending) begin
                    halted = 1;
                    halt_pending = 0;
                end
            end else begin
                if (bus.load) m_ir = bus.in;
                if (bus.s) plan(m_ir);
            end
        end
    end

    // Compare DUT against the model every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (reset) model_reset();
                check($sformatf("trace@%0t", $time), 64'(dut_snap()), 64'(model_now()));
            end
        end
    end

    // Start one instruction and record outputs at each falling edge until w=1.
    // noise drives load=1/in=FFFF/s=1 during the first busy cycles.
    task automatic run(input logic [15:0] word, input bit do_load, input bit noise);
        tr.delete();
        @(negedge clk);
        bus.in   = word;
        bus.load = do_load;
        bus.s    = 1'b1;
        @(posedge clk);
        #1;
        bus.s    = noise;
        bus.load = noise;
        bus.in   = 16'hFFFF;
        @(negedge clk);
        tr.push_back(dut_snap());
        while (!bus.w && tr.size() < 12) begin
            if (tr.size() == 3) begin
                bus.s    = 1'b0;
                bus.load = 1'b0;
            end
            @(negedge clk);
            tr.push_back(dut_snap());
        end
        bus.s    = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_write;
        reset    = 1'b1;
        bus.s    = 1'b0;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset w", 64'(bus.w), 64'd1);
        check("reset enables", 64'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}), 64'd0);
        check("reset dp_in", 64'(bus.datapath_in), 64'h0);
        cmp_en = 1;
        @(posedge clk);
        #2 reset = 1'b0;

        // MOV R3,#-2 with load and s together
        run(16'hD3FE, 1'b1, 1'b0);
        check("movi edges", 64'(tr.size()), 64'd3);
        check("movi decode w", 64'(tr[0].w), 64'd0);
        check("movi writenum", 64'(tr[1].writenum), 64'd3);
        check("movi vsel/write", 64'({tr[1].vsel, tr[1].write}), 64'b11);
        check("movi dp_in", 64'(tr[1].dp_in), 64'hFFFE);

        // ADD R2,R1,R0<<1 loaded ahead of s; busy-time load/s must be ignored
        @(negedge clk);
        bus.in   = 16'hA148;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        run(16'hFFFF, 1'b0, 1'b1);
        check("add edges", 64'(tr.size()), 64'd6);
        check("add get_a", 64'({tr[1].readnum, tr[1].loada}), 64'({3'd1, 1'b1}));
        check("add get_b", 64'({tr[2].readnum, tr[2].loadb}), 64'({3'd0, 1'b1}));
        check("add alu", 64'({tr[3].shift, tr[3].aluop, tr[3].loadc, tr[3].asel, tr[3].bsel}),
              64'({2'b01, 2'b00, 1'b1, 1'b1, 1'b1}));
        check("add write", 64'({tr[4].writenum, tr[4].write, tr[4].vsel}), 64'({3'd2, 1'b1, 1'b0}));
        check("add ir kept", 64'(tr[5].dp_in), 64'h0008);
        check("add back idle", 64'(tr[5].w), 64'd1);

        // CMP R5,R6
        run(16'hAD06, 1'b1, 1'b0);
        check("cmp edges", 64'(tr.size()), 64'd5);
        check("cmp alu", 64'({tr[3].loads, tr[3].loadc, tr[3].aluop}), 64'({1'b1, 1'b0, 2'b01}));
        any_write = 1'b0;
        foreach (tr[i]) any_write |= tr[i].write;
        check("cmp no write", 64'(any_write), 64'd0);

        // MOV R1,R2<<2
        run(16'hC032, 1'b1, 1'b0);
        check("movr edges", 64'(tr.size()), 64'd5);
        check("movr alu", 64'({tr[2].asel, tr[2].shift, tr[2].aluop}), 64'({1'b0, 2'd2, 2'd0}));
        check("movr writenum", 64'(tr[3].writenum), 64'd1);

        // MVN R4,R7
        run(16'hB887, 1'b1, 1'b0);
        check("mvn edges", 64'(tr.size()), 64'd5);
        check("mvn alu", 64'({tr[2].asel, tr[2].aluop}), 64'({1'b0, 2'd3}));

        // AND R6,R3,R5
        run(16'hB3C5, 1'b1, 1'b0);
        check("and edges", 64'(tr.size()), 64'd6);
        check("and aluop", 64'(tr[3].aluop), 64'd2);
        check("and writenum", 64'(tr[4].writenum), 64'd6);

        // MOV R0,#127
        run(16'hD07F, 1'b1, 1'b0);
        check("movi2 edges", 64'(tr.size()), 64'd3);
        check("movi2 dp_in", 64'(tr[1].dp_in), 64'h007F);

        // Asynchronous reset while ADD sits in GET_B
        @(negedge clk);
        bus.in   = 16'hA148;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset get_b", 64'({bus.loadb, bus.w}), 64'b10);
        #1 reset = 1'b1;
        #1;
        check("async reset w", 64'(bus.w), 64'd1);
        check("async reset enables", 64'({bus.loadb, bus.loada, bus.write, bus.readnum}), 64'd0);
        check("async reset ir", 64'(bus.datapath_in), 64'h0);
        @(posedge clk);
        #2 reset = 1'b0;

`ifdef CTRL_ILLEGAL_TRAP_EN
        run(16'h0000, 1'b1, 1'b0);
        check("illegal stays busy", 64'(tr[tr.size()-1].w), 64'd0);
        check("illegal flag", 64'(tr[tr.size()-1].illegal), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("halt reset flag", 64'({bus.illegal, bus.w}), 64'b01);
        @(posedge clk);
        #2 reset = 1'b0;
`else
        run(16'h0000, 1'b1, 1'b0);
        check("illegal nop edges", 64'(tr.size()), 64'd2);
        check("illegal flag tied", 64'(tr[0].illegal), 64'd0);
        run(16'hC800, 1'b1, 1'b0);
        check("illegal sub edges", 64'(tr.size()), 64'd2);
`endif

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
